imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Byte-stream program loader for the calculator CPU's instruction memory: the hardware
//   writer counterpart to a file-based image load. Receives program bytes on a valid/ready
//   stream, packs them into 32-bit words, writes them to instMem from address 0 upward, and
//   holds the CPU in reset until the image is complete. Runs in the slow module clock domain.
// PARAMETERS
//   ADDR_WIDTH  10    word-address width of instruction memory
//   MAX_WORDS   1024  image capacity in words (must be <= 2**ADDR_WIDTH)
// PORTS
//   clk0            in   1             slow module clock; all logic rises on posedge clk0
//   reset           in   1             synchronous, active-high reset
//   start           in   1             in DONE/ERR: begin a fresh load (ignored in LOAD/FLUSH)
//   in_valid        in   1             byte available on in_data
//   in_data         in   8             program byte, big-endian within each word
//   in_last         in   1             qualifies final byte of the image (with in_valid)
//   in_ready        out  1             loader accepts a byte this cycle
//   mem_we          out  1             one-cycle instruction-memory write strobe
//   mem_addr        out  ADDR_WIDTH    word address for mem_we
//   mem_wdata       out  32            word for mem_we
//   cpu_reset_hold  out  1             hold CPU (and PC) in reset while 1
//   done            out  1             image fully written
//   error           out  1             image exceeded MAX_WORDS
//   word_count      out  ADDR_WIDTH+1  words written in current load
// BEHAVIOUR
//   - Byte accepted on posedge when in_valid & in_ready; all outputs registered.
//   - Reset: state=LOAD, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset_hold=1,
//     done=0, error=0, word_count=0, byte index=0, shift register cleared.
//   - States: LOAD -> FLUSH -> DONE; LOAD -> ERR; DONE/ERR -start-> LOAD.
//   - LOAD: in_ready=1. Byte k (0..3) of a word lands in bits [31-8k -: 8] (first byte = MSB).
//     Accepting byte 3 at edge N: mem_we=1, mem_addr=word_count, mem_wdata=packed word during
//     cycle N+1; word_count increments at edge N; byte index wraps to 0. No bubble: in_ready
//     stays 1, so a byte may be accepted every cycle.
//   - in_last accepted with byte k<3: unfilled low bytes padded with 0x00, word written as
//     above. Any in_last -> FLUSH (in_ready=0 for that cycle, holding the final write).
//   - FLUSH: one cycle, then DONE. DONE: done=1, cpu_reset_hold=0, in_ready=0, mem_we=0;
//     done rises exactly one cycle after the final mem_we cycle.
//   - Overflow: byte accepted while word_count==MAX_WORDS and byte index==0 -> ERR on that
//     edge, no write issued; ERR: error=1, in_ready=0, cpu_reset_hold=1, done=0.
//   - start in DONE/ERR: next edge -> LOAD, word_count=0, byte index=0, done=0, error=0,
//     cpu_reset_hold=1. start in LOAD/FLUSH has no effect.
//   - Reset mid-load: partial word discarded, all outputs to reset values next edge; words
//     already written stay in memory (loader does not clear memory).
//   - mem_addr/mem_wdata hold last written values when mem_we=0.
//   - in_valid low: no state change (gaps of any length legal mid-word).
// TESTING
//   1. Bytes 20 08 00 05 20 09 00 03 (last on 8th), back-to-back -> writes addr0=0x20080005,
//      addr1=0x20090003, done=1 one cycle after 2nd write, word_count=2, cpu_reset_hold=0.
//   2. Bytes AA BB CC DD EE (last on EE) -> addr0=0xAABBCCDD, addr1=0xEE000000, word_count=2.
//   3. Test 1 stream with 3 idle cycles of in_valid=0 between every byte -> identical writes,
//      no spurious mem_we.
//   4. MAX_WORDS=2, 9 bytes -> two writes only, error=1, in_ready=0, cpu_reset_hold=1, done=0.
//   5. Reset after 6 bytes of test 1 -> only addr0 written; reload test 1 -> writes restart
//      at addr0, done=1.
//   6. From DONE, pulse start, send 11 22 33 44 last -> done drops, addr0=0x11223344,
//      word_count=1, done=1 again.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream into the loader plus the instruction-memory write port out of it
interface imem_loader_if #(parameter int ADDR_WIDTH = 10);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  modport master (output in_valid, in_data, in_last, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input in_valid, in_data, in_last, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit instruction words and holds the CPU in reset until loaded
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                clk0,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.slave        s,
  output logic                cpu_reset_hold,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] word_count
);
  typedef enum logic [1:0] {LOAD, FLUSH, DONE, ERR} state_e;
  localparam logic [ADDR_WIDTH:0] MAXW = (ADDR_WIDTH+1)'(MAX_WORDS);
  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           shift_q, shift_d, word;
  logic [ADDR_WIDTH:0]   wc_q, wc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  acc;
  assign s.in_ready      = state_q == LOAD;
  assign s.mem_we        = we_q;
  assign s.mem_addr      = addr_q;
  assign s.mem_wdata     = wdata_q;
  assign cpu_reset_hold  = state_q != DONE;
  assign done            = state_q == DONE;
  assign error           = state_q == ERR;
  assign word_count      = wc_q;
  always_ff @(posedge clk0) begin
    if (reset) begin
      state_q <= LOAD;
      idx_q   <= '0;
      shift_q <= '0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  // byte k lands at [31-8k -: 8]; unfilled low bytes of a short final word stay zero
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    wc_d    = wc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word    = shift_q | ({s.in_data, 24'h0} >> {idx_q, 3'b000});
    acc     = s.in_valid && state_q == LOAD;
    if (acc && wc_q == MAXW && idx_q == 2'd0) begin
      state_d = ERR;
    end else if (acc) begin
      if (s.in_last || idx_q == 2'd3) begin
        we_d    = 1'b1;
        addr_d  = wc_q[ADDR_WIDTH-1:0];
        wdata_d = word;
        wc_d    = wc_q + 1'b1;
        idx_d   = 2'd0;
        shift_d = '0;
      end else begin
        idx_d   = idx_q + 2'd1;
        shift_d = word;
      end
      state_d = s.in_last ? FLUSH : LOAD;
    end else if (state_q == FLUSH) begin
      state_d = DONE;
    end else if ((state_q == DONE || state_q == ERR) && start) begin
      state_d = LOAD;
      wc_d    = '0;
      idx_d   = 2'd0;
      shift_d = '0;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed image loads plus random streams against a queue-based loader model
module tb_imem_loader;
  localparam int AW = 2;
  localparam int MW = 2;
  localparam int P_LOAD = 0, P_FLUSH = 1, P_DONE = 2, P_ERR = 3;
  logic clk0 = 1'b0, reset = 1'b1, start = 1'b0;
  logic cpu_reset_hold, done, error;
  logic [AW:0] word_count;
  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();
  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
    .clk0(clk0), .reset(reset), .start(start), .s(bus),
    .cpu_reset_hold(cpu_reset_hold), .done(done), .error(error), .word_count(word_count)
  );
  always #5 clk0 = ~clk0;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [31:0] dutmem [4];
  int writes = 0;
  always @(posedge clk0) if (bus.mem_we === 1'b1) begin
    dutmem[bus.mem_addr] <= bus.mem_wdata;
    writes <= writes + 1;
  end

  // reference: bytes of the current word collected in a queue, packed arithmetically when complete
  int ph = P_LOAD, wc = 0, exp_addr = 0;
  bit exp_we = 1'b0;
  logic [31:0] exp_wdata = '0;
  byte unsigned bq[$];
  always @(posedge clk0) begin
    exp_we = 1'b0;
    if (reset) begin
      ph = P_LOAD; wc = 0; bq.delete(); exp_addr = 0; exp_wdata = '0;
    end else if (ph == P_LOAD && bus.in_valid) begin
      if (bq.size() == 0 && wc == MW) ph = P_ERR;
      else begin
        bq.push_back(bus.in_data);
        if (bq.size() == 4 || bus.in_last) begin
          exp_wdata = '0;
          foreach (bq[i]) exp_wdata = exp_wdata | (32'(bq[i]) << (24 - 8 * i));
          exp_we = 1'b1; exp_addr = wc; wc++; bq.delete();
        end
        if (bus.in_last) ph = P_FLUSH;
      end
    end else if (ph == P_FLUSH) ph = P_DONE;
    else if ((ph == P_DONE || ph == P_ERR) && start) begin
      ph = P_LOAD; wc = 0; bq.delete();
    end
  end

  always @(negedge clk0) begin
    chk("in_ready", 32'(bus.in_ready), 32'(ph == P_LOAD));
    chk("done", 32'(done), 32'(ph == P_DONE));
    chk("error", 32'(error), 32'(ph == P_ERR));
    chk("cpu_reset_hold", 32'(cpu_reset_hold), 32'(ph != P_DONE));
    chk("word_count", 32'(word_count), 32'(wc));
    chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
    chk("mem_wdata", bus.mem_wdata, exp_wdata);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk0); #1; end
  endtask
  task automatic send(input logic [7:0] b, input logic last, input int gap);
    bus.in_valid = 1'b1; bus.in_data = b; bus.in_last = last;
    tick(1);
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = $urandom;
    tick(gap);
  endtask
  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask
  task automatic pulse_reset();
    reset = 1'b1; tick(1); reset = 1'b0;
  endtask

  logic [7:0] t1 [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h03};
  logic [7:0] t2 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
  logic [7:0] t6 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int w0;

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset hold", 32'(cpu_reset_hold), 32'd1);
    chk("reset mem_wdata", bus.mem_wdata, 32'h0);
    // back-to-back two-word image
    w0 = writes;
    foreach (t1[i]) send(t1[i], i == 7, 0);
    tick(3);
    chk("t1 word0", dutmem[0], 32'h20080005);
    chk("t1 word1", dutmem[1], 32'h20090003);
    chk("t1 writes", 32'(writes - w0), 32'd2);
    chk("t1 count", 32'(word_count), 32'd2);
    chk("t1 done", 32'(done), 32'd1);
    chk("t1 hold", 32'(cpu_reset_hold), 32'd0);
    // reload from DONE
    pulse_start();
    chk("t6 done drop", 32'(done), 32'd0);
    foreach (t6[i]) send(t6[i], i == 3, 0);
    tick(3);
    chk("t6 word0", dutmem[0], 32'h11223344);
    chk("t6 count", 32'(word_count), 32'd1);
    chk("t6 done", 32'(done), 32'd1);
    // short final word padded with zeros
    pulse_start();
    foreach (t2[i]) send(t2[i], i == 4, 0);
    tick(3);
    chk("t2 word0", dutmem[0], 32'hAABBCCDD);
    chk("t2 word1", dutmem[1], 32'hEE000000);
    chk("t2 count", 32'(word_count), 32'd2);
    // gaps between bytes
    pulse_start();
    w0 = writes;
    foreach (t1[i]) send(t1[i], i == 7, 3);
    tick(3);
    chk("t3 writes", 32'(writes - w0), 32'd2);
    chk("t3 word0", dutmem[0], 32'h20080005);
    chk("t3 word1", dutmem[1], 32'h20090003);
    chk("t3 done", 32'(done), 32'd1);
    // overflow past capacity
    pulse_start();
    w0 = writes;
    foreach (t1[i]) send(t1[i], 1'b0, 0);
    send(8'h77, 1'b0, 0);
    tick(2);
    chk("t4 writes", 32'(writes - w0), 32'd2);
    chk("t4 error", 32'(error), 32'd1);
    chk("t4 in_ready", 32'(bus.in_ready), 32'd0);
    chk("t4 hold", 32'(cpu_reset_hold), 32'd1);
    chk("t4 done", 32'(done), 32'd0);
    // reset mid-load then reload
    pulse_reset();
    w0 = writes;
    for (int i = 0; i < 6; i++) send(t1[i], 1'b0, 0);
    pulse_reset();
    tick(2);
    chk("t5 partial writes", 32'(writes - w0), 32'd1);
    chk("t5 count", 32'(word_count), 32'd0);
    foreach (t1[i]) send(t1[i], i == 7, 0);
    tick(3);
    chk("t5 writes", 32'(writes - w0), 32'd3);
    chk("t5 word1", dutmem[1], 32'h20090003);
    chk("t5 done", 32'(done), 32'd1);
    // random streams with random gaps, starts and resets
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 200) == 0;
      start = ($urandom % 8) == 0;
      bus.in_valid = ($urandom % 3) != 0;
      bus.in_data = 8'($urandom);
      bus.in_last = ($urandom % 10) == 0;
      tick(1);
    end
    reset = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
